// File: rtl/msx_cart_bus_if.sv
// MSX cartridge pin front-end: synchronises the Z80 strobes and turns each access into one
// valid/ready transaction on the internal VDP I/O bus, returning read data on td with twait.
module msx_cart_bus_if #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       n_ce,
  input  logic       n_twr,
  input  logic       n_trd,
  input  logic [1:0] ta,
  input  logic [7:0] td_in,
  output logic [7:0] td_out,
  output logic       td_oe,
  output logic       twait,
  output logic       bus_valid,
  output logic       bus_write,
  output logic [1:0] bus_address,
  output logic [7:0] bus_wdata,
  input  logic       bus_ready,
  input  logic [7:0] bus_rdata,
  input  logic       bus_rdata_en
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(WAIT_TIMEOUT);

  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_DATA, RD_DRIVE, RELEASE} state_t;

  logic [SYNC_STAGES-1:0]      ce_sync, wr_sync, rd_sync;
  logic [SYNC_STAGES-1:0][1:0] a_sync;
  logic [SYNC_STAGES-1:0][7:0] d_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ce_sync <= '1;
      wr_sync <= '1;
      rd_sync <= '1;
      a_sync  <= '0;
      d_sync  <= '0;
    end else begin
      ce_sync <= {ce_sync[SYNC_STAGES-2:0], n_ce};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], n_twr};
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], n_trd};
      a_sync  <= {a_sync[SYNC_STAGES-2:0], ta};
      d_sync  <= {d_sync[SYNC_STAGES-2:0], td_in};
    end
  end

  logic       ce, wr, rd;
  logic [1:0] a;
  logic [7:0] d;
  assign ce = ce_sync[SYNC_STAGES-1];
  assign wr = wr_sync[SYNC_STAGES-1];
  assign rd = rd_sync[SYNC_STAGES-1];
  assign a  = a_sync[SYNC_STAGES-1];
  assign d  = d_sync[SYNC_STAGES-1];

  state_t     state, state_d;
  logic [7:0] wait_cnt, cnt_d;
  logic       rd_abort, abort_d;
  logic       valid_d, write_d, oe_d, twait_d;
  logic [1:0] addr_d;
  logic [7:0] wdata_d, tdo_d;

  logic accept, in_rd_wait, data_hit, timeout, released, abort_eff, rd_finish;
  assign accept     = bus_valid & bus_ready;
  assign in_rd_wait = (state == RD_REQ) || (state == RD_DATA);
  assign data_hit   = bus_rdata_en & (((state == RD_REQ) & accept) | (state == RD_DATA));
  assign timeout    = in_rd_wait && !data_hit && ((wait_cnt + 8'd1) == TIMEOUT_CNT);
  assign released   = rd | ce;
  // An abort is remembered so a later strobe cannot revive a read the Z80 already gave up on.
  assign abort_eff  = rd_abort | released;
  assign rd_finish  = data_hit | timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      rd_abort    <= 1'b0;
      bus_valid   <= 1'b0;
      bus_write   <= 1'b0;
      bus_address <= '0;
      bus_wdata   <= '0;
      td_out      <= '0;
      td_oe       <= 1'b0;
      twait       <= 1'b0;
    end else begin
      state       <= state_d;
      wait_cnt    <= cnt_d;
      rd_abort    <= abort_d;
      bus_valid   <= valid_d;
      bus_write   <= write_d;
      bus_address <= addr_d;
      bus_wdata   <= wdata_d;
      td_out      <= tdo_d;
      td_oe       <= oe_d;
      twait       <= twait_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (!ce && !wr)      state_d = WR_REQ;
        else if (!ce && !rd) state_d = RD_REQ;
      end
      WR_REQ:   if (accept) state_d = RELEASE;
      RD_REQ: begin
        if (rd_finish)   state_d = abort_eff ? IDLE : RD_DRIVE;
        else if (accept) state_d = RD_DATA;
      end
      RD_DATA:  if (rd_finish) state_d = abort_eff ? IDLE : RD_DRIVE;
      RD_DRIVE: if (released) state_d = IDLE;
      RELEASE:  if (ce || (wr && rd)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; the counter keeps running after an abort so an
  // unanswered aborted read still falls back to IDLE.
  always_comb begin
    cnt_d   = wait_cnt;
    abort_d = rd_abort;
    valid_d = bus_valid;
    write_d = bus_write;
    addr_d  = bus_address;
    wdata_d = bus_wdata;
    tdo_d   = td_out;
    oe_d    = td_oe;
    twait_d = twait;
    case (state)
      IDLE: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        oe_d    = 1'b0;
        twait_d = 1'b0;
        if (!ce && !wr) begin
          valid_d = 1'b1;
          write_d = 1'b1;
          addr_d  = a;
          wdata_d = d;
        end else if (!ce && !rd) begin
          valid_d = 1'b1;
          write_d = 1'b0;
          addr_d  = a;
          twait_d = 1'b1;
        end
      end
      WR_REQ: if (accept) valid_d = 1'b0;
      RD_REQ, RD_DATA: begin
        cnt_d   = wait_cnt + 8'd1;
        abort_d = abort_eff;
        twait_d = !abort_eff;
        if (accept) valid_d = 1'b0;
        if (rd_finish) begin
          valid_d = 1'b0;
          twait_d = 1'b0;
          if (!abort_eff) begin
            tdo_d = data_hit ? bus_rdata : 8'hFF;
            oe_d  = 1'b1;
          end
        end
      end
      RD_DRIVE: if (released) oe_d = 1'b0;
      default: ;
    endcase
  end

endmodule
